// File: rtl/ex_muldiv_if.sv
// EX-side request/result bundle for the iterative mul/div unit.
// master: pipeline EX stage, slave: ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            cancel_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            busy_o;
  logic            stall_req_o;

  modport master (
    output start_i, op_i, a_i, b_i, cancel_i,
    input  result_o, ready_o, busy_o, stall_req_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, cancel_i,
    output result_o, ready_o, busy_o, stall_req_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Radix-2 iterative unsigned MUL/MULHU/DIVU/REMU beside the EX ALU.
// Shares one {hi, lo} shift register between multiply and restoring divide.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            stall;

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [XLEN:0]   rs;
  logic            ge;
  logic [XLEN-1:0] div_hi, div_lo;
  logic [XLEN-1:0] nxt_hi, nxt_lo;

  // One iteration of each algorithm; op_q[1] picks divide.
  always_comb begin
    mul_sum = {1'b0, hi_q}
            + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    rs      = {hi_q, lo_q[XLEN-1]};
    ge      = rs >= {1'b0, opb_q};
    div_hi  = ge ? rs[XLEN-1:0] - opb_q
                 : rs[XLEN-1:0];
    div_lo  = {lo_q[XLEN-2:0], ge};

    nxt_hi  = op_q[1] ? div_hi : mul_hi;
    nxt_lo  = op_q[1] ? div_lo : mul_lo;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.cancel_i) begin
          stall = 1'b1;
          op_d  = bus.op_i;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = bus.op_i[1] ? bus.a_i : bus.b_i;
          opb_d = bus.op_i[1] ? bus.b_i : bus.a_i;
          if (bus.op_i[1] && bus.b_i == '0) begin
            state_d = DONE;
            rdy_d   = 1'b1;
            res_d   = bus.op_i[0] ? bus.a_i : '1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        if (bus.cancel_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          hi_d  = nxt_hi;
          lo_d  = nxt_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            res_d   = (op_q == 2'b01) ? nxt_hi
                    : (op_q == 2'b11) ? nxt_hi
                    : nxt_lo;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.result_o    = res_q;
  assign bus.ready_o     = rdy_q;
  assign bus.busy_o      = busy_q;
  assign bus.stall_req_o = stall;

endmodule
